// File: rtl/pump_controller.sv
// Debounced hysteresis pump driver with minimum off time, run timeout and latched fault.
// Optional dry-run check is compiled in when PUMP_CTRL_DRYRUN_EN is defined.
module pump_controller #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int MIN_OFF_CYCLES  = 64,
    parameter int MAX_RUN_CYCLES  = 1024,
    parameter int DRYRUN_CYCLES   = 256,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] indicator,
    input  logic       fault_clr,
    output logic       pump_en,
    output logic [1:0] state,
    output logic [3:0] level_stable,
    output logic       fault,
    output logic [1:0] fault_code
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_COOL  = 2'b10,
        S_FAULT = 2'b11
    } state_t;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_TIMEOUT = 2'b01;
    localparam logic [1:0] FC_DRYRUN  = 2'b10;
    localparam logic [1:0] FC_INVALID = 2'b11;

    localparam logic [3:0] LVL_EMPTY = 4'b0001;
    localparam logic [3:0] LVL_HIGH  = 4'b1000;

    localparam logic [CNT_W-1:0] DEB_LIMIT = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(MAX_RUN_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LAST  = CNT_W'(MIN_OFF_CYCLES - 1);

    // Reject parameter sets the counters cannot represent.
    generate
        if (DEBOUNCE_CYCLES < 1 || MIN_OFF_CYCLES < 1 || MAX_RUN_CYCLES < 1 ||
            DRYRUN_CYCLES >= MAX_RUN_CYCLES || CNT_W < 1 ||
            MAX_RUN_CYCLES > (1 << CNT_W) || MIN_OFF_CYCLES > (1 << CNT_W) ||
            DEBOUNCE_CYCLES >= (1 << CNT_W)) begin : g_bad_params
            $error("pump_controller: invalid parameter combination");
        end
    endgenerate

    state_t           state_reg, state_next;
    logic [1:0]       code_reg, code_next;
    logic [3:0]       ind_reg;
    logic [3:0]       level_reg;
    logic [CNT_W-1:0] deb_cnt_reg;
    logic [CNT_W-1:0] run_cnt_reg;
    logic [CNT_W-1:0] off_cnt_reg;
    logic             pump_reg;
    logic             fault_reg;
    logic             level_multi;

    // Two or more bits set means the indicator stage is reporting nonsense.
    assign level_multi = (level_reg & 4'(level_reg - 4'd1)) != 4'd0;

    // Debounce: deb_cnt_reg is the length of the current run of identical samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ind_reg     <= 4'd0;
            deb_cnt_reg <= '0;
            level_reg   <= 4'd0;
        end else begin
            ind_reg <= indicator;
            if (indicator != ind_reg) begin
                deb_cnt_reg <= CNT_W'(1);
            end else if (deb_cnt_reg < DEB_LIMIT) begin
                deb_cnt_reg <= deb_cnt_reg + CNT_W'(1);
            end
            if (deb_cnt_reg == DEB_LIMIT) begin
                level_reg <= ind_reg;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        code_next  = code_reg;
        case (state_reg)
            S_IDLE: begin
                if (level_reg == LVL_EMPTY) begin
                    state_next = S_RUN;
                end else if (level_multi) begin
                    state_next = S_FAULT;
                    code_next  = FC_INVALID;
                end
            end
            S_RUN: begin
                if (level_reg == LVL_HIGH) begin
                    state_next = S_COOL;
                end else if (run_cnt_reg == RUN_LAST) begin
                    state_next = S_FAULT;
                    code_next  = FC_TIMEOUT;
`ifdef PUMP_CTRL_DRYRUN_EN
                end else if (run_cnt_reg == CNT_W'(DRYRUN_CYCLES - 1) &&
                             level_reg == LVL_EMPTY) begin
                    state_next = S_FAULT;
                    code_next  = FC_DRYRUN;
`endif
                end else if (level_multi) begin
                    state_next = S_FAULT;
                    code_next  = FC_INVALID;
                end
            end
            S_COOL: begin
                if (off_cnt_reg == OFF_LAST) begin
                    state_next = S_IDLE;
                end
            end
            S_FAULT: begin
                if (fault_clr) begin
                    state_next = S_COOL;
                    code_next  = FC_NONE;
                end
            end
            default: begin
                state_next = S_IDLE;
                code_next  = FC_NONE;
            end
        endcase
    end

    // Counters restart whenever their state is (re)entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            code_reg    <= FC_NONE;
            pump_reg    <= 1'b0;
            fault_reg   <= 1'b0;
            run_cnt_reg <= '0;
            off_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            code_reg    <= code_next;
            pump_reg    <= (state_next == S_RUN);
            fault_reg   <= (state_next == S_FAULT);
            run_cnt_reg <= (state_reg == S_RUN && state_next == S_RUN) ?
                           run_cnt_reg + CNT_W'(1) : '0;
            off_cnt_reg <= (state_reg == S_COOL && state_next == S_COOL) ?
                           off_cnt_reg + CNT_W'(1) : '0;
        end
    end

    assign pump_en      = pump_reg;
    assign state        = state_reg;
    assign level_stable = level_reg;
    assign fault        = fault_reg;
    assign fault_code   = code_reg;

endmodule
